cap_touch_scanner: RTL and testbench
====================================

# cap_touch_scanner

Parametrised capacitive touch scanner for the whack-a-mole pads. Drives the shared sense line and time-stamps each channel's discharge. Thresholds and debounces the result into a touched bitmap, with sticky per-channel hit flags that the processor reads and clears through memory-mapped I/O. It generalises the fixed 9-sensor path to N channels, adds configurable timing and debounce, and optionally learns a per-channel baseline after reset.

## Interface
- N_CH, 9: number of sensor channels.
- CNT_W, 12: width of the discharge counter and stored counts.
- CHARGE_CYCLES, 64: cycles the drive line is held high per scan (≥1).
- TIMEOUT, 4095: maximum measure count; must fit in CNT_W.
- THRESHOLD, 200: absolute touch threshold (non-calibrated mode).
- DELTA, 40: margin above baseline (calibrated mode).
- DEBOUNCE, 3: consecutive agreeing scans required to change state (≥1).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, the FSM finishes its current scan and then parks in IDLE.
- capacitive_sensors_in  in  N_CH  raw pad inputs (asynchronous).
- capacitive_sensors_out  out  1  shared charge drive.
- touched  out  N_CH  debounced touch state.
- hits  out  N_CH  sticky rising-edge flags of touched.
- clear_mask  in  N_CH  one-cycle pulse; clears the selected hits bits.
- scan_done  out  1  one-cycle pulse when touched/hits update.
- cal_done  out  1  high once the baseline is valid (tied high without the macro).
- last_count  out  N_CH*CNT_W  per-channel count of the most recent scan; channel i is at bits [i*CNT_W +: CNT_W].

## Operation
- Inputs pass through a 2-flop synchroniser. The fixed 2-cycle offset is common to all channels and is not compensated.
- FSM states: IDLE, CHARGE, MEASURE, EVAL.
- IDLE: if enable=1, go to CHARGE on the next cycle.
- CHARGE: drive out=1 for CHARGE_CYCLES cycles, then go to MEASURE.
- MEASURE: drive out=0. The counter counts from 0.
  - Each channel latches the counter on the first cycle its synchronised input is 0.
  - Channels still high when the counter reaches TIMEOUT latch TIMEOUT.
  - Exit to EVAL when all channels are latched or the counter reaches TIMEOUT, whichever comes first.
- EVAL (one cycle):
  - Compute raw touch per channel: count > THRESHOLD, or count > baseline+DELTA when calibrated. The sum is saturated at 2^CNT_W−1.
  - Update the per-channel debounce counter (width clog2(DEBOUNCE+1)). It resets to 0 on any agreement with the current touched value. touched flips when the counter reaches DEBOUNCE, and the counter then resets.
  - Update last_count and pulse scan_done.
  - Next state is CHARGE if enable=1, else IDLE.
- hits[i] sets on a 0→1 transition of touched[i]. It clears when clear_mask[i]=1. A set and a clear in the same cycle resolve to set.
- Reset mid-scan: all state is cleared asynchronously and the FSM returns to IDLE. No partial results are published.
- Reset values: capacitive_sensors_out=0, touched=0, hits=0, scan_done=0, last_count=0, cal_done=0 (1 without the macro). The FSM is in IDLE with all counters at 0.

## Timing
- Full scan with enable held high: CHARGE_CYCLES + M + 1 cycles, where M is the MEASURE length (1..TIMEOUT+1).
- The first CHARGE begins 1 cycle after enable rises in IDLE.
- scan_done is asserted in the cycle after EVAL, coincident with the updated touched, hits and last_count.
- Latency from a pad change to touched changing: DEBOUNCE scans, measured from the first scan that sees the change.
- clear_mask takes effect on the next clock edge.

## Configuration
- CAP_BASELINE_CAL_EN defined: the first 4 scans after reset are calibration scans.
  - Each channel's baseline is the minimum count seen over those scans.
  - touched and hits stay 0 during calibration.
  - cal_done rises with the 4th scan_done.
  - Subsequent scans compare against baseline+DELTA.
- CAP_BASELINE_CAL_EN undefined: no baseline storage is built, the absolute THRESHOLD compare is used from the first scan, and cal_done=1.

## Structure
- A shared package cap_touch_pkg holds the FSM state enum, the calibration scan count (4) and a saturating add function.
- Sub-module cap_channel, instantiated N_CH times, contains:
  - synchroniser
  - count latch
  - optional baseline
  - debounce counter
  - touched and hits flops
- The top level holds the FSM, the shared counter and the drive output.

## Test plan
Benches use N_CH=3, CNT_W=8, CHARGE_CYCLES=4, TIMEOUT=63, THRESHOLD=20, DELTA=10, DEBOUNCE=2.
- Timing, macro off: all pads discharge instantly (0) → each scan is 4+3+1 cycles, last_count ≈2 per channel, touched=000, and scan_done pulses every 8 cycles.
- Debounce: ch1 falls at count 30 on every scan → touched[1]=1 after the 2nd scan_done, hits[1]=1. ch1 returns to count 2 → touched[1]=0 after 2 scans, hits[1] still 1.
- Sticky clear: clear_mask=010 pulsed in the same cycle as a new rising edge of touched[1] → hits[1] stays 1. A clear pulse on a later cycle → 0.
- Timeout: ch2 held high → last_count[2]=63, MEASURE lasts 64 cycles, touched[2]=1 after 2 scans.
- Macro on: baseline ch0 counts 15,12,14,13 → cal_done after 4th scan, baseline=12. Count 21 → not touched; count 23 → touched after 2 scans.
- Reset mid-MEASURE: out=0, touched=hits=0, FSM in IDLE immediately. The next scan starts 1 cycle after reset falls, with enable=1.

Source files
------------

// File: rtl/cap_touch_pkg.sv
// Shared types and helpers for the capacitive touch scanner.
package cap_touch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        MEASURE = 2'd2,
        EVAL    = 2'd3
    } state_t;

    localparam int CAL_SCANS = 4;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/cap_channel.sv
// One sensor channel: synchroniser, discharge-time latch, optional baseline
// (CAP_BASELINE_CAL_EN), debounce and sticky hit flag.
module cap_channel
    import cap_touch_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int TIMEOUT   = 4095,
    parameter int THRESHOLD = 200,
    parameter int DELTA     = 40,
    parameter int DEBOUNCE  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sense,
    input  logic             scan_start,
    input  logic             measure,
    input  logic             eval,
    input  logic             cal_active,
    input  logic             cal_first,
    input  logic [CNT_W-1:0] count,
    input  logic             clear,
    output logic             done,
    output logic             touched,
    output logic             hits,
    output logic [CNT_W-1:0] last_count
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [31:0] MAX_CNT = 32'((64'd1 << CNT_W) - 64'd1);

    logic [1:0]       sync;
    logic             latched;
    logic [CNT_W-1:0] cnt_lat;
    logic [DB_W-1:0]  db_cnt;
    logic [31:0]      limit;
    logic             raw;
    logic             hit_now;
    logic             flip;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], sense};
    end

    // Timed-out channels latch the counter value, which equals TIMEOUT then.
    assign hit_now = measure && !latched && (!sync[1] || count == CNT_W'(TIMEOUT));
    assign done    = latched || hit_now;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latched <= 1'b0;
            cnt_lat <= '0;
        end else if (scan_start) begin
            latched <= 1'b0;
        end else if (hit_now) begin
            latched <= 1'b1;
            cnt_lat <= count;
        end
    end

`ifdef CAP_BASELINE_CAL_EN
    logic [CNT_W-1:0] baseline;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            baseline <= '0;
        else if (eval && cal_active && (cal_first || cnt_lat < baseline))
            baseline <= cnt_lat;
    end

    assign limit = sat_add(32'(baseline), 32'(DELTA), MAX_CNT);
`else
    logic unused_cal;
    assign unused_cal = cal_first;
    assign limit      = 32'(THRESHOLD);
`endif

    assign raw  = 32'(cnt_lat) > limit;
    assign flip = eval && !cal_active && (raw != touched) && (db_cnt == DB_W'(DEBOUNCE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt     <= '0;
            touched    <= 1'b0;
            hits       <= 1'b0;
            last_count <= '0;
        end else begin
            if (eval) last_count <= cnt_lat;
            if (eval && !cal_active) begin
                if (raw == touched || flip) db_cnt <= '0;
                else                        db_cnt <= db_cnt + 1'b1;
                if (flip) touched <= raw;
            end
            // A new rising edge wins over a simultaneous clear.
            if (flip && raw) hits <= 1'b1;
            else if (clear)  hits <= 1'b0;
        end
    end

endmodule

// File: rtl/cap_touch_scanner.sv
// N-channel capacitive touch scanner: scan FSM, shared discharge counter and
// drive line. Define CAP_BASELINE_CAL_EN to learn per-channel baselines.
module cap_touch_scanner
    import cap_touch_pkg::*;
#(
    parameter int N_CH          = 9,
    parameter int CNT_W         = 12,
    parameter int CHARGE_CYCLES = 64,
    parameter int TIMEOUT       = 4095,
    parameter int THRESHOLD     = 200,
    parameter int DELTA         = 40,
    parameter int DEBOUNCE      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_CH-1:0]       capacitive_sensors_in,
    output logic                  capacitive_sensors_out,
    output logic [N_CH-1:0]       touched,
    output logic [N_CH-1:0]       hits,
    input  logic [N_CH-1:0]       clear_mask,
    output logic                  scan_done,
    output logic                  cal_done,
    output logic [N_CH*CNT_W-1:0] last_count
);

    localparam int CC_W = $clog2(CHARGE_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CC_W-1:0]  chg_cnt;
    logic [N_CH-1:0]  done;
    logic             cal_active;
    logic             cal_first;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            cnt                    <= '0;
            chg_cnt                <= '0;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state                  <= CHARGE;
                        chg_cnt                <= '0;
                        capacitive_sensors_out <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (chg_cnt == CC_W'(CHARGE_CYCLES - 1)) begin
                        state                  <= MEASURE;
                        cnt                    <= '0;
                        capacitive_sensors_out <= 1'b0;
                    end else begin
                        chg_cnt <= chg_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (&done || cnt == CNT_W'(TIMEOUT)) state <= EVAL;
                    else                                 cnt   <= cnt + 1'b1;
                end
                EVAL: begin
                    scan_done <= 1'b1;
                    if (enable) begin
                        state                  <= CHARGE;
                        chg_cnt                <= '0;
                        capacitive_sensors_out <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAP_BASELINE_CAL_EN
    localparam int CAL_W = $clog2(CAL_SCANS + 1);
    logic [CAL_W-1:0] cal_cnt;

    // cal_done rises together with the scan_done of the last calibration scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cal_cnt  <= '0;
            cal_done <= 1'b0;
        end else if (state == EVAL && !cal_done) begin
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == CAL_W'(CAL_SCANS - 1)) cal_done <= 1'b1;
        end
    end

    assign cal_active = !cal_done;
    assign cal_first  = (cal_cnt == '0);
`else
    assign cal_done   = 1'b1;
    assign cal_active = 1'b0;
    assign cal_first  = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        cap_channel #(
            .CNT_W    (CNT_W),
            .TIMEOUT  (TIMEOUT),
            .THRESHOLD(THRESHOLD),
            .DELTA    (DELTA),
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .sense     (capacitive_sensors_in[i]),
            .scan_start(state == CHARGE),
            .measure   (state == MEASURE),
            .eval      (state == EVAL),
            .cal_active(cal_active),
            .cal_first (cal_first),
            .count     (cnt),
            .clear     (clear_mask[i]),
            .done      (done[i]),
            .touched   (touched[i]),
            .hits      (hits[i]),
            .last_count(last_count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Scoreboard bench for cap_touch_scanner. Pads are modelled so that a channel
// configured with latch count L drops L-2 cycles after the drive falls.
module tb_cap_touch_scanner;

    localparam int N_CH = 3, CNT_W = 8, CC = 4, TO = 63, THR = 20, DLT = 10, DB = 2;
`ifdef CAP_BASELINE_CAL_EN
    localparam logic CD_RST = 1'b0;
`else
    localparam logic CD_RST = 1'b1;
`endif

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic [N_CH-1:0]       pads;
    logic                  capacitive_sensors_out;
    logic [N_CH-1:0]       touched;
    logic [N_CH-1:0]       hits;
    logic [N_CH-1:0]       clear_mask = '0;
    logic                  scan_done;
    logic                  cal_done;
    logic [N_CH*CNT_W-1:0] last_count;

    always #5 clock = ~clock;

    cap_touch_scanner #(
        .N_CH(N_CH), .CNT_W(CNT_W), .CHARGE_CYCLES(CC), .TIMEOUT(TO),
        .THRESHOLD(THR), .DELTA(DLT), .DEBOUNCE(DB)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .capacitive_sensors_in (pads),
        .capacitive_sensors_out(capacitive_sensors_out),
        .touched               (touched),
        .hits                  (hits),
        .clear_mask            (clear_mask),
        .scan_done             (scan_done),
        .cal_done              (cal_done),
        .last_count            (last_count)
    );

    typedef struct {
        logic [N_CH-1:0]       t;
        logic [N_CH-1:0]       h;
        logic [N_CH*CNT_W-1:0] lc;
        logic                  cd;
        int                    gap;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    int   cyc = 0, last_sd = 0;
    int   k = 0;
    int   lat[N_CH] = '{2, 2, 2};

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) k <= capacitive_sensors_out ? 0 : k + 1;

    always_comb begin
        pads = '1;
        for (int i = 0; i < N_CH; i++)
            if (!capacitive_sensors_out && k >= lat[i] - 2) pads[i] = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every scan_done pops one expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (scan_done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scan_done: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("touched", 64'(touched), 64'(mon_e.t));
                    check("hits", 64'(hits), 64'(mon_e.h));
                    check("last_count", 64'(last_count), 64'(mon_e.lc));
                    check("cal_done", 64'(cal_done), 64'(mon_e.cd));
                    if (mon_e.gap >= 0) check("scan_gap", 64'(cyc - last_sd), 64'(mon_e.gap));
                end
                last_sd = cyc;
            end
        end
    end

    // Configure pads for the next scan, queue its expectation, wait for scan_done.
    // clear_mask is pulsed clr_at cycles after the call (0 = never).
    task automatic scan(input int l0, input int l1, input int l2,
                        input logic [N_CH-1:0] t, input logic [N_CH-1:0] h,
                        input logic cd, input bit gap_chk,
                        input int clr_at, input logic [N_CH-1:0] clr_val);
        exp_t e;
        int   mx;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        mx = 0;
        for (int i = 0; i < N_CH; i++) if (lat[i] > mx) mx = lat[i];
        if (mx > TO) mx = TO;
        e.t   = t;
        e.h   = h;
        e.cd  = cd;
        e.lc  = {8'((l2 > TO) ? TO : l2), 8'((l1 > TO) ? TO : l1), 8'((l0 > TO) ? TO : l0)};
        e.gap = gap_chk ? (CC + mx + 2) : -1;
        q.push_back(e);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clock);
            clear_mask = (n == clr_at) ? clr_val : '0;
            if (scan_done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL scan_wait: got no scan_done expected one within 200 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_out", 64'(capacitive_sensors_out), 64'd0);
        check("rst_touched", 64'(touched), 64'd0);
        check("rst_hits", 64'(hits), 64'd0);
        check("rst_scan_done", 64'(scan_done), 64'd0);
        check("rst_last_count", 64'(last_count), 64'd0);
        check("rst_cal_done", 64'(cal_done), 64'(CD_RST));
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;

`ifdef CAP_BASELINE_CAL_EN
        scan(15, 2, 2, 3'b000, 3'b000, 1'b0, 1'b0, 0, '0);
        scan(12, 2, 2, 3'b000, 3'b000, 1'b0, 1'b1, 0, '0);
        scan(14, 2, 2, 3'b000, 3'b000, 1'b0, 1'b1, 0, '0);
        scan(13, 2, 2, 3'b000, 3'b000, 1'b1, 1'b1, 0, '0);
        scan(21, 2, 2, 3'b000, 3'b000, 1'b1, 1'b1, 0, '0);
        scan(23, 2, 2, 3'b000, 3'b000, 1'b1, 1'b1, 0, '0);
        scan(23, 2, 2, 3'b001, 3'b001, 1'b1, 1'b1, 0, '0);
        scan(2, 2, 255, 3'b001, 3'b001, 1'b1, 1'b1, 0, '0);
`else
        scan(2, 2, 2, 3'b000, 3'b000, 1'b1, 1'b0, 0, '0);
        scan(2, 2, 2, 3'b000, 3'b000, 1'b1, 1'b1, 0, '0);
        scan(2, 30, 2, 3'b000, 3'b000, 1'b1, 1'b1, 0, '0);
        scan(2, 30, 2, 3'b010, 3'b010, 1'b1, 1'b1, 0, '0);
        scan(2, 2, 2, 3'b010, 3'b010, 1'b1, 1'b1, 0, '0);
        scan(2, 2, 2, 3'b000, 3'b010, 1'b1, 1'b1, 0, '0);
        scan(2, 30, 2, 3'b000, 3'b000, 1'b1, 1'b1, 1, 3'b010);
        // Clear lands in the EVAL cycle where touched[1] rises again.
        scan(2, 30, 2, 3'b010, 3'b010, 1'b1, 1'b1, 35, 3'b010);
        scan(2, 2, 255, 3'b010, 3'b010, 1'b1, 1'b1, 0, '0);
        scan(2, 2, 255, 3'b100, 3'b110, 1'b1, 1'b1, 0, '0);
`endif

        // Reset in the middle of a MEASURE phase.
        lat[0] = 2; lat[1] = 2; lat[2] = 255;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_out", 64'(capacitive_sensors_out), 64'd0);
        check("midrst_touched", 64'(touched), 64'd0);
        check("midrst_hits", 64'(hits), 64'd0);
        check("midrst_last_count", 64'(last_count), 64'd0);
        check("midrst_cal_done", 64'(cal_done), 64'(CD_RST));
        @(negedge clock);
        check("midrst_idle_out", 64'(capacitive_sensors_out), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("restart_out", 64'(capacitive_sensors_out), 64'd1);
        scan(2, 2, 2, 3'b000, 3'b000, CD_RST, 1'b0, 0, '0);

        repeat (5) @(negedge clock);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
